// File: rtl/mem_apb_bridge.sv
// mem_apb_bridge: processor data-memory port to APB master bridge.
// Optional feature: define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait cycles.
module mem_apb_bridge #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic [7:0]  addr,
    input  logic [31:0] dout,
    input  logic        write,
    input  logic        enable,
    input  logic        sel,
    output logic [31:0] mem_in,
    output logic        ready,
    output logic        err,
    output logic        busy,
    output logic [7:0]  paddr,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    state_t state, state_nx;
    logic done, timeout;
    assign done = state == ACCESS && pready;
`ifdef APB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;
    assign timeout = state == ACCESS && !pready && wait_cnt == CW'(TIMEOUT_CYCLES - 1);
    // Count consecutive ACCESS cycles without pready; cleared when leaving ACCESS.
    always_ff @(posedge Clock or negedge Resetn)
        if (!Resetn) wait_cnt <= '0;
        else wait_cnt <= (state == ACCESS && !pready && !timeout) ? wait_cnt + 1'b1 : '0;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif
    // Next-state: a valid request leaves IDLE, SETUP always advances, ACCESS waits for pready or timeout.
    always_comb begin
        state_nx = state;
        state_nx = state == IDLE  ? ((enable && sel) ? SETUP : IDLE) :
                   state == SETUP ? ACCESS :
                   (done || timeout) ? IDLE : ACCESS;
    end
    // State and all outputs are registered, derived from the next state so they align with it.
    always_ff @(posedge Clock or negedge Resetn)
        if (!Resetn) begin
            state   <= IDLE;
            psel    <= 1'b0;
            penable <= 1'b0;
            busy    <= 1'b0;
            ready   <= 1'b0;
            err     <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
            pwrite  <= 1'b0;
            mem_in  <= '0;
        end else begin
            state   <= state_nx;
            psel    <= state_nx != IDLE;
            penable <= state_nx == ACCESS;
            busy    <= state_nx != IDLE;
            ready   <= done || timeout;
            err     <= (done && pslverr) || timeout;
            if (state == IDLE && enable && sel) begin
                paddr  <= addr;
                pwdata <= dout;
                pwrite <= write;
            end
            if (done && !pwrite && !pslverr) mem_in <= prdata;
        end
endmodule

// File: tb/tb_mem_apb_bridge.sv
// tb_mem_apb_bridge: scoreboard bench with an APB slave model and a transaction-level reference.
module tb_mem_apb_bridge;
    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic [7:0]  addr = '0;
    logic [31:0] dout = '0;
    logic        write = 1'b0, enable = 1'b0, sel = 1'b0;
    logic [31:0] mem_in;
    logic        ready, err, busy;
    logic [7:0]  paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata = '0;
    logic        pready = 1'b0, pslverr = 1'b0;

    mem_apb_bridge #(.TIMEOUT_CYCLES(4)) dut (
        .Clock(Clock), .Resetn(Resetn), .addr(addr), .dout(dout), .write(write),
        .enable(enable), .sel(sel), .mem_in(mem_in), .ready(ready), .err(err),
        .busy(busy), .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [31:0] mem;
        logic        err;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] model_mem = '0;
    int          wait_n = 0;
    logic [31:0] s_rdata = '0;
    logic        s_err = 1'b0;
    logic [7:0]  e_addr = '0;
    logic [31:0] e_wdata = '0;
    logic        e_write = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // APB slave: inserts wait_n wait states, checks the address phase stays stable.
    initial begin
        int acc;
        acc = 0;
        forever begin
            @(negedge Clock);
            if (psel && penable) begin
                chk("paddr_stable", {24'h0, paddr}, {24'h0, e_addr});
                chk("pwdata_stable", pwdata, e_wdata);
                chk("pwrite_stable", {31'h0, pwrite}, {31'h0, e_write});
                pready  = acc >= wait_n;
                prdata  = pready ? s_rdata : $urandom;
                pslverr = pready ? s_err : 1'($urandom);
                acc++;
            end else begin
                pready  = 1'b0;
                prdata  = $urandom;
                pslverr = 1'($urandom);
                acc     = 0;
            end
        end
    end

    // Monitor: every ready pulse consumes one expected completion.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            if (ready) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL spurious_ready: ready=1 with no request outstanding, required 0");
                end else begin
                    e = q.pop_front();
                    chk("mem_in", mem_in, e.mem);
                    chk("err", {31'h0, err}, {31'h0, e.err});
                end
            end else if (err) begin
                chk("err_without_ready", {31'h0, err}, 32'h0);
            end
        end
    end

    task automatic push_exp(input logic e_err);
        exp_t e;
        e.mem = model_mem;
        e.err = e_err;
        q.push_back(e);
    endtask

    // One accepted request; called at a negedge (possibly the ready cycle of the previous one).
    task automatic run(input logic w, input logic [7:0] a, input logic [31:0] d, input int wn,
                       input logic [31:0] rd, input logic se, input bit poke);
        int setups, accs, got;
        wait_n = wn; s_rdata = rd; s_err = se;
        e_addr = a; e_wdata = d; e_write = w;
        if (!w && !se) model_mem = rd;
        push_exp(se);
        enable = 1'b1; sel = 1'b1; write = w; addr = a; dout = d;
        setups = 0; accs = 0; got = 0;
        for (int lat = 1; lat <= 300; lat++) begin
            @(negedge Clock);
            if (lat == 1) begin
                enable = 1'b0; sel = 1'b0;
                addr = 8'($urandom); dout = $urandom; write = 1'($urandom);
            end
            if (poke && lat == 2) begin enable = 1'b1; sel = 1'b1; end
            if (poke && lat == 3) begin enable = 1'b0; sel = 1'b0; end
            if (psel && !penable) setups++;
            if (psel && penable) accs++;
            if (ready) begin got = lat; break; end
        end
        chk("latency", got, 3 + wn);
        chk("setup_cycles", setups, 1);
        chk("access_cycles", accs, wn + 1);
    endtask

    initial begin
        int cnt, got, accs;
        repeat (3) @(negedge Clock);
        chk("rst_psel", {31'h0, psel}, 0);
        chk("rst_penable", {31'h0, penable}, 0);
        chk("rst_ready", {31'h0, ready}, 0);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_paddr", {24'h0, paddr}, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_pwrite", {31'h0, pwrite}, 0);
        chk("rst_mem_in", mem_in, 0);
        Resetn = 1'b1;
        @(negedge Clock);
        run(1'b0, 8'h12, 32'h0, 0, 32'hDEADBEEF, 1'b0, 1'b0);
        repeat (2) @(negedge Clock);
        run(1'b1, 8'h34, 32'h0000ABCD, 3, $urandom, 1'b0, 1'b0);
        // enable without sel must not start a transfer
        enable = 1'b1; sel = 1'b0; addr = 8'h55;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clock);
            enable = 1'b0;
            if (psel || busy) cnt++;
        end
        chk("sel0_ignored", cnt, 0);
        run(1'b0, 8'hA5, 32'h0, 2, 32'h12345678, 1'b0, 1'b1);
        run(1'b1, 8'h01, 32'hCAFEF00D, 0, 32'h0, 1'b0, 1'b0);
        run(1'b0, 8'h02, 32'h0, 1, 32'h0BADF00D, 1'b1, 1'b0);
        run(1'b0, 8'h03, 32'h0, 0, 32'h600DF00D, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            run(1'($urandom), 8'($urandom), $urandom, int'($urandom_range(0, 4)), $urandom,
                $urandom_range(0, 3) == 0, 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge Clock);
        end
        // reset in the middle of ACCESS aborts with no ready pulse
        @(negedge Clock);
        wait_n = 1000; e_addr = 8'h77; e_wdata = 32'h5A5A5A5A; e_write = 1'b0;
        enable = 1'b1; sel = 1'b1; addr = 8'h77; dout = 32'h5A5A5A5A; write = 1'b0;
        @(negedge Clock);
        enable = 1'b0; sel = 1'b0;
        repeat (3) @(negedge Clock);
        chk("pre_reset_penable", {31'h0, penable}, 1);
        #2 Resetn = 1'b0;
        #1;
        chk("async_rst_psel", {31'h0, psel}, 0);
        chk("async_rst_penable", {31'h0, penable}, 0);
        chk("async_rst_busy", {31'h0, busy}, 0);
        chk("async_rst_mem_in", mem_in, 0);
        model_mem = '0;
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(negedge Clock);
            if (ready || psel) cnt++;
        end
        chk("post_reset_quiet", cnt, 0);
        // slave never answers: timeout abort, or indefinite wait without the timeout feature
        e_addr = 8'h9C; e_wdata = 32'h0; e_write = 1'b0;
        s_rdata = 32'hFEEDFACE; s_err = 1'b0; wait_n = 1000;
`ifdef APB_TIMEOUT_EN
        push_exp(1'b1);
`else
        model_mem = 32'hFEEDFACE;
        push_exp(1'b0);
`endif
        enable = 1'b1; sel = 1'b1; addr = 8'h9C; dout = 32'h0; write = 1'b0;
        got = 0; accs = 0;
        for (int lat = 1; lat <= 130; lat++) begin
            @(negedge Clock);
            if (lat == 1) begin enable = 1'b0; sel = 1'b0; end
            if (psel && penable) accs++;
            if (ready) begin got = lat; break; end
        end
`ifdef APB_TIMEOUT_EN
        chk("timeout_latency", got, 6);
        chk("timeout_access_cycles", accs, 4);
        chk("timeout_psel_dropped", {31'h0, psel}, 0);
`else
        chk("no_timeout", got, 0);
        chk("wait_access_cycles", accs, 129);
        wait_n = 0;
        for (int lat = 1; lat <= 5; lat++) begin
            @(negedge Clock);
            if (ready) begin got = lat; break; end
        end
        chk("late_completion", {31'h0, got != 0}, 1);
`endif
        repeat (4) @(negedge Clock);
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
